// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device transmitter.
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StGap,
      StBitHigh,
      StBitLow,
      StDone
   } ps2_state_e;

   localparam int unsigned FRAME_BITS = 11;
   localparam int unsigned ENTRY_W    = 11;
   localparam int ERR_PARITY = 0;
   localparam int ERR_START  = 1;
   localparam int ERR_STOP   = 2;

   // Entry is {err[2:0], data[7:0]}; result bit 0 is the first bit on the wire.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [ENTRY_W-1:0] entry);
      logic [7:0] data;
      logic [2:0] err;
      data = entry[7:0];
      err  = entry[10:8];
      build_frame = {1'b1 ^ err[ERR_STOP], (~^data) ^ err[ERR_PARITY], data, err[ERR_START]};
   endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; writes when full are dropped.
module ps2_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 11
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_wr    = i_wr_en & ~o_full;
   assign w_rd    = i_rd_en & ~o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_count   = r_count;

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-to-host transmitter: queues scancodes and clocks them out as
// 11-bit frames with optional error injection and host-inhibit retry.
module ps2_device_tx
   import ps2_pkg::*;
#(
   parameter int unsigned HIGH_CYC = 300,
   parameter int unsigned LOW_CYC  = 300,
   parameter int unsigned GAP_CYC  = 1000,
   parameter int unsigned DEPTH    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              in_data,
   input  logic [2:0]              in_err,
   input  logic                    ps2_clk_i,
   output logic                    ps2_clk_oe,
   output logic                    ps2_dat_oe,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    frame_abort,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int unsigned MAX_HL  = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
   localparam int unsigned MAX_CYC = (GAP_CYC > MAX_HL) ? GAP_CYC : MAX_HL;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
   localparam int unsigned BIT_W   = $clog2(FRAME_BITS);
   // The line still reads low for the synchroniser delay after we release it.
   localparam int unsigned INH_MIN = 4;

   logic                  r_sync1;
   logic                  r_sync2;
   logic                  w_clk_s;
   ps2_state_e            r_state;
   ps2_state_e            w_state_nxt;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [BIT_W-1:0]      r_bit;
   logic [BIT_W-1:0]      w_bit_nxt;
   logic [FRAME_BITS-1:0] r_frame;
   logic [FRAME_BITS-1:0] w_frame_nxt;
   logic [ENTRY_W-1:0]    w_head;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic                  w_pop;
   logic                  w_clk_oe;
   logic                  w_dat_oe;
   logic                  w_done;
   logic                  w_abort;

   ps2_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_wr_en   (in_valid),
      .i_wr_data ({in_err, in_data}),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_count   (fifo_count),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_state <= StIdle;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_frame <= '1;
      end else begin
         r_sync1 <= ps2_clk_i;
         r_sync2 <= r_sync1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_frame <= w_frame_nxt;
      end
   end

   assign w_clk_s = r_sync2;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_frame_nxt = r_frame;
      w_pop       = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      w_clk_oe    = 1'b0;
      w_dat_oe    = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_cnt_nxt = '0;
            if (!w_fifo_empty) w_state_nxt = StGap;
         end
         StGap: begin
            if (!w_clk_s) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
               w_state_nxt = StBitHigh;
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_frame_nxt = build_frame(w_head);
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StBitHigh: begin
            if (r_cnt >= CNT_W'(INH_MIN) && !w_clk_s) begin
               w_abort     = 1'b1;
               w_state_nxt = StGap;
               w_cnt_nxt   = '0;
            end else begin
               w_dat_oe = ~r_frame[r_bit];
               if (r_cnt == CNT_W'(HIGH_CYC - 1)) begin
                  w_state_nxt = StBitLow;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         StBitLow: begin
            w_clk_oe = 1'b1;
            w_dat_oe = ~r_frame[r_bit];
            if (r_cnt == CNT_W'(LOW_CYC - 1)) begin
               w_cnt_nxt = '0;
               if (r_bit == BIT_W'(FRAME_BITS - 1)) begin
                  w_state_nxt = StDone;
               end else begin
                  w_bit_nxt   = r_bit + 1'b1;
                  w_state_nxt = StBitHigh;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StDone: begin
            w_pop       = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign in_ready    = ~w_fifo_full;
   assign ps2_clk_oe  = w_clk_oe;
   assign ps2_dat_oe  = w_dat_oe;
   assign busy        = (r_state != StIdle);
   assign frame_done  = w_done;
   assign frame_abort = w_abort;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Randomized bench: a host receiver model decodes frames off the wire and
// compares them against a queue of written entries.
module tb_ps2_device_tx;

   localparam int H = 20;
   localparam int L = 20;
   localparam int G = 60;
   localparam int D = 8;
   localparam int FRAME_CYC = 11 * (H + L) + G + 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_err;
   logic       host_inh;
   logic       ps2_clk_i;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       busy;
   logic       frame_done;
   logic       frame_abort;
   logic [3:0] fifo_count;

   always #5 clk = ~clk;

   // Open-collector clock line with pull-up; either side may hold it low.
   assign ps2_clk_i = ~(ps2_clk_oe | host_inh);

   ps2_device_tx #(
      .HIGH_CYC (H),
      .LOW_CYC  (L),
      .GAP_CYC  (G),
      .DEPTH    (D)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_err      (in_err),
      .ps2_clk_i   (ps2_clk_i),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_dat_oe  (ps2_dat_oe),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_abort (frame_abort),
      .fifo_count  (fifo_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [10:0] exp_q[$];
   int          exp_done  = 0;
   int          done_cnt  = 0;
   int          abort_cnt = 0;
   int          cyc       = 0;

   // Receiver state
   int          rx_n      = 0;
   logic [10:0] rx_bits;
   int          t_start   = 0;
   int          t_done    = 0;
   bit          gap_armed = 0;
   bit          start_ok  = 0;
   logic        prev_clk_oe = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n) begin
         rx_n        = 0;
         gap_armed   = 0;
         start_ok    = 0;
         prev_clk_oe = 1'b0;
      end else begin
         if (host_inh) begin
            rx_n     = 0;
            start_ok = 0;
         end else if (ps2_clk_oe && !prev_clk_oe) begin
            // Host samples data on each falling edge of the clock line.
            if (rx_n == 0) begin
               t_start  = cyc;
               start_ok = 1;
               if (gap_armed) check_eq("gap_len", 32'((cyc - t_done) >= (G + H)), 32'd1);
            end
            rx_bits[rx_n] = ~ps2_dat_oe;
            rx_n++;
            if (rx_n == 11) begin
               logic [10:0] e;
               rx_n = 0;
               if (exp_q.size() == 0) begin
                  check_eq("rx_unexpected", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("rx_data", 32'(rx_bits[8:1]), 32'(e[7:0]));
                  check_eq("rx_perr", 32'(($countones(rx_bits[9:1]) % 2) == 0), 32'(e[8]));
                  check_eq("rx_serr", 32'(rx_bits[0] != 1'b0), 32'(e[9]));
                  check_eq("rx_perr_stop", 32'(rx_bits[10] != 1'b1), 32'(e[10]));
               end
            end
         end
         if (frame_done) begin
            done_cnt++;
            if (start_ok) check_eq("done_latency", 32'(cyc - t_start), 32'(10 * H + 11 * L));
            start_ok  = 0;
            t_done    = cyc;
            gap_armed = 1;
         end
         if (frame_abort) begin
            abort_cnt++;
            gap_armed = 0;
         end
         prev_clk_oe = ps2_clk_oe;
      end
   end

   logic [7:0] bd[16];
   logic [2:0] be[16];

   // Back-to-back writes into an empty, idle queue: the first D are accepted.
   task automatic write_burst(input int n);
      for (int i = 0; i < n; i++) begin
         in_data  = bd[i];
         in_err   = be[i];
         in_valid = 1'b1;
         check_eq("in_ready", 32'(in_ready), 32'(i < D));
         if (i < D) begin
            exp_q.push_back({be[i], bd[i]});
            exp_done++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int frames);
      bit ok;
      ok = 0;
      for (int c = 0; c < frames * FRAME_CYC + 200; c++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !busy) begin
            ok = 1;
            break;
         end
      end
      check_eq("drain_timeout", 32'(ok), 32'd1);
      check_eq("fifo_empty", 32'(fifo_count), 32'd0);
      check_eq("done_count", 32'(done_cnt), 32'(exp_done));
   endtask

   task automatic wait_rx_bit(input int n, input logic clk_lvl, output bit ok);
      ok = 0;
      for (int c = 0; c < 2 * FRAME_CYC; c++) begin
         @(posedge clk);
         #1;
         if (rx_n == n && ps2_clk_oe == clk_lvl) begin
            ok = 1;
            break;
         end
      end
      check_eq("wait_bit", 32'(ok), 32'd1);
   endtask

   initial begin
      bit ok;
      int k;
      int ab0;
      int dn0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_err   = '0;
      host_inh = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", 32'(in_ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_count", 32'(fifo_count), 32'd0);
      check_eq("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Plain 0x1C
      bd[0] = 8'h1C; be[0] = 3'd0;
      write_burst(1);
      wait_drain(1);

      // Parity, start, stop error injection in order
      bd[0] = 8'h1C; be[0] = 3'd1;
      bd[1] = 8'h1C; be[1] = 3'd2;
      bd[2] = 8'h1C; be[2] = 3'd4;
      write_burst(3);
      wait_drain(3);

      // Overflow: DEPTH+1 writes, last one dropped
      for (int i = 0; i <= D; i++) begin
         bd[i] = 8'($urandom);
         be[i] = 3'd0;
      end
      write_burst(D + 1);
      check_eq("full_ready", 32'(in_ready), 32'd0);
      check_eq("full_count", 32'(fifo_count), 32'(D));
      wait_drain(D);

      // Host inhibit during bit 5 of 0xF0
      ab0   = abort_cnt;
      bd[0] = 8'hF0; be[0] = 3'd0;
      write_burst(1);
      wait_rx_bit(5, 1'b0, ok);
      repeat (8) @(posedge clk);
      #1;
      host_inh = 1'b1;
      repeat (150) @(posedge clk);
      #1;
      check_eq("inh_abort_cnt", 32'(abort_cnt - ab0), 32'd1);
      check_eq("inh_count", 32'(fifo_count), 32'd1);
      check_eq("inh_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      host_inh = 1'b0;
      wait_drain(1);
      check_eq("inh_abort_once", 32'(abort_cnt - ab0), 32'd1);

      // Asynchronous reset mid-frame, while bit 3 (a 0) is on the wire
      dn0   = done_cnt;
      bd[0] = 8'h52; be[0] = 3'd0;
      write_burst(1);
      wait_rx_bit(4, 1'b1, ok);
      repeat (3) @(posedge clk);
      #2;
      check_eq("pre_rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd3);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_pulses", 32'({frame_done, frame_abort}), 32'd0);
      exp_done -= exp_q.size();
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2 * FRAME_CYC) @(posedge clk);
      #1;
      check_eq("post_rst_no_done", 32'(done_cnt - dn0), 32'd0);
      check_eq("post_rst_busy", 32'(busy), 32'd0);

      // Randomized bursts with occasional error injection
      for (int r = 0; r < 5; r++) begin
         k = $urandom_range(1, D);
         for (int i = 0; i < k; i++) begin
            bd[i] = 8'($urandom);
            be[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         end
         write_burst(k);
         wait_drain(k);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_device_tx.md
PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 Parameter HIGH_CYC, default 300: clk cycles that ps2 clock is released per bit (data setup phase).
REQ-002 Parameter LOW_CYC, default 300: clk cycles that ps2 clock is driven low per bit.
REQ-003 Parameter GAP_CYC, default 1000: clk cycles the clock line must read high before a frame starts.
REQ-004 Parameter DEPTH, default 8, power of two >= 2: queued frame entries.
REQ-005 clk  in  1  system clock; all logic is on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  write request for a queue entry.
REQ-008 in_ready  out  1  queue can accept an entry (not full).
REQ-009 in_data  in  8  scancode byte.
REQ-010 in_err  in  3  error injection: [0] bad parity, [1] bad start, [2] bad stop.
REQ-011 ps2_clk_i  in  1  sampled PS/2 clock line (asynchronous).
REQ-012 ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release.
REQ-013 ps2_dat_oe  out  1  1 = drive PS/2 data low; 0 = release.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 frame_done  out  1  one-cycle pulse when a frame completes.
REQ-016 frame_abort  out  1  one-cycle pulse when the host inhibits a frame.
REQ-017 fifo_count  out  $clog2(DEPTH)+1  number of queued entries.

Function
REQ-018 A write occurs when in_valid and in_ready are both high; {in_err,in_data} is stored as one 11-bit entry.
REQ-019 in_ready = (fifo_count != DEPTH); a write and a pop in the same cycle keep fifo_count unchanged.
REQ-020 Frame bits in order: start (0), data[0..7] LSB first, parity (~^data, inverted when err[0]), stop (1); err[1] inverts start and err[2] inverts stop.
REQ-021 ps2_dat_oe = ~current_bit; a 1 releases the line.
REQ-022 ps2_clk_i passes through a 2-flop synchroniser before any use.
REQ-023 States: IDLE, GAP, BIT_HIGH, BIT_LOW, DONE.
REQ-024 IDLE -> GAP when the FIFO is non-empty.
REQ-025 In GAP, a counter counts cycles with the synchronised clock high and clears on any low cycle; GAP -> BIT_HIGH on reaching GAP_CYC, with bit index 0 loaded from the FIFO head.
REQ-026 BIT_HIGH lasts HIGH_CYC cycles with ps2_clk_oe=0 and ps2_dat_oe set on entry, then -> BIT_LOW.
REQ-027 BIT_LOW lasts LOW_CYC cycles with ps2_clk_oe=1, then increments the bit index: -> BIT_HIGH if index < 11, else -> DONE.
REQ-028 DONE lasts 1 cycle: pop the FIFO head, pulse frame_done, release both lines, then -> IDLE.
REQ-029 Host inhibit: in BIT_HIGH, from count 4 onward, a synchronised clock low -> frame_abort pulse, release both lines, no pop, -> GAP with the gap counter cleared; the same entry is retransmitted from the start bit.
REQ-030 Inhibit is ignored in BIT_LOW, DONE, and BIT_HIGH counts 0-3.
REQ-031 Outside BIT_HIGH/BIT_LOW, ps2_clk_oe=0 and ps2_dat_oe=0.
REQ-032 Frame duration from leaving GAP to DONE is exactly 11*(HIGH_CYC+LOW_CYC) cycles.

Reset
REQ-033 Asserting rst_n low immediately forces ps2_clk_oe=0, ps2_dat_oe=0, busy=0, frame_done=0, frame_abort=0, fifo_count=0 and state IDLE, including mid-frame; queued entries are discarded.
REQ-034 After reset, in_ready=1 and both synchroniser flops are 1.

Structure
REQ-035 Shared package ps2_pkg holds: the state enum, FRAME_BITS=11, the err bit indices (ERR_PARITY=0, ERR_START=1, ERR_STOP=2), and the entry width 11.
REQ-036 The queue is the sub-module ps2_sync_fifo (DEPTH x 11, show-ahead head, count output); the synchroniser stays inline.

Verification (HIGH=LOW=300, GAP=1000, host models open-collector pull-ups)
REQ-037 Write 0x1C with err=0 -> the host receiver decodes 0x1C with parity=0 and stop=1; frame_done pulses 6600 cycles after leaving GAP; fifo_count returns to 0.
REQ-038 Write 0x1C three times with err=1, 2, 4 in turn -> the receiver flags a parity error, then a start error, then a stop error, in that order.
REQ-039 Issue DEPTH+1 back-to-back writes -> in_ready=0 after the 8th write and the 9th write is not accepted; frames 0..7 arrive in order, each separated by >= 1000 high cycles.
REQ-040 Host holds the clock low for 200 us during bit 5 of 0xF0 -> frame_abort pulses once and fifo_count stays 1; after release plus 1000 cycles, a full 0xF0 frame is received.
REQ-041 Pulse rst_n low mid-frame (bit 3) -> both oe outputs are 0 with no clock edge required; fifo_count=0; no frame_done follows.
